fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 46 ++++
 rtl/fetch_unit_rep_counter.sv | 45 ++++
 rtl/fetch_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared cpu package: instruction field layout, opcode constants, fetch FSM encoding
// and small decode/parity helpers used by the fetch unit.
package fetch_unit_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_LSB = 12;
  localparam int OPC_W   = 4;
  localparam int CNT_LSB = 8;
  localparam int CNT_W   = 4;
  localparam int OPD_LSB = 0;
  localparam int OPD_W   = 8;

  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_LD  = 4'h1;
  localparam logic [OPC_W-1:0] OP_ST  = 4'h2;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h3;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h4;
  localparam logic [OPC_W-1:0] OP_MOV = 4'h6;
  localparam logic [OPC_W-1:0] OP_BR  = 4'h8;
  localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_FULL    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_e;

  function automatic logic [OPC_W-1:0] instr_opcode(input logic [INSTR_W-1:0] w);
    return w[OPC_LSB +: OPC_W];
  endfunction

  function automatic logic [CNT_W-1:0] instr_count(input logic [INSTR_W-1:0] w);
    return w[CNT_LSB +: CNT_W];
  endfunction

  function automatic logic [OPD_W-1:0] instr_operand(input logic [INSTR_W-1:0] w);
    return w[OPD_LSB +: OPD_W];
  endfunction

  // Even parity: the XOR over data and parity bit must be zero.
  function automatic logic parity_fail(input logic [INSTR_W-1:0] w, input logic p);
    return ^{w, p};
  endfunction

endpackage

// File: rtl/fetch_unit_rep_counter.sv
// Saturating repeat counter; rep_stop flags that the count has reached the limit
// taken from the executing instruction's count field.
module rep_counter
  import fetch_unit_pkg::*;
#(
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rep_reset,
  input  logic             rep_enable,
  input  logic [CNT_W-1:0] limit,
  output logic             rep_stop
);

  localparam logic [REP_W-1:0] CNT_MAX = {REP_W{1'b1}};
  localparam logic [REP_W-1:0] CNT_ONE = {{(REP_W-1){1'b0}}, 1'b1};

  logic [REP_W-1:0] count_q;
  logic [REP_W-1:0] count_d;

  // next count: clear wins over increment, increment holds at the top value
  always_comb begin
    count_d = count_q;
    if (rep_reset) begin
      count_d = {REP_W{1'b0}};
    end else if (rep_enable && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= {REP_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign rep_stop = ({{CNT_W{1'b0}}, count_q} >= {{REP_W{1'b0}}, limit});

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC, IR, one-entry prefetch buffer and repeat counter.
// Optional macro FETCH_PARITY_EN adds imem_parity / parity_err word checking.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int REP_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_reset,
  input  logic              pc_enable,
  input  logic              pc_load,
  input  logic              ir_enable,
  input  logic              rep_reset,
  input  logic              rep_enable,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
`ifdef FETCH_PARITY_EN
  input  logic              imem_parity,
  output logic              parity_err,
`endif
  output logic [3:0]        opcode_old,
  output logic [3:0]        opcode_new,
  output logic [7:0]        operand,
  output logic              rep_stop,
  output logic              fetch_stall
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   stale_addr_q, stale_addr_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [INSTR_W-1:0]  pb_q, pb_d;
  logic                pb_valid_q, pb_valid_d;
  logic                redirect;
  logic [ADDR_W-1:0]   redirect_pc;

  assign redirect    = pc_reset | pc_load;
  assign redirect_pc = pc_reset ? {ADDR_W{1'b0}} : ADDR_W'(instr_operand(ir_q));

  // fetch FSM next state and datapath updates
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    stale_addr_d = stale_addr_q;
    ir_d         = ir_q;
    pb_d         = pb_q;
    pb_valid_d   = pb_valid_q;
    case (state_q)
      ST_FETCH, ST_WAIT: begin
        if (redirect) begin
          pc_d       = redirect_pc;
          pb_valid_d = 1'b0;
          // a request already seen by memory must be drained before refetching
          if ((state_q == ST_WAIT) && !imem_ack) begin
            state_d      = ST_DISCARD;
            stale_addr_d = pc_q;
          end else begin
            state_d = ST_FETCH;
          end
        end else if (imem_ack) begin
          pb_d       = imem_rdata;
          pb_valid_d = 1'b1;
          pc_d       = pc_q + PC_ONE;
          state_d    = ST_FULL;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_FULL: begin
        if (redirect) begin
          pc_d       = redirect_pc;
          pb_valid_d = 1'b0;
          state_d    = ST_FETCH;
        end else if (pc_enable) begin
          ir_d       = ir_enable ? pb_q : ir_q;
          pb_valid_d = 1'b0;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_FULL;
        end
      end
      ST_DISCARD: begin
        pc_d       = redirect ? redirect_pc : pc_q;
        pb_valid_d = 1'b0;
        if (imem_ack) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DISCARD;
        end
      end
      default: begin
        state_d    = ST_FETCH;
        pb_valid_d = 1'b0;
      end
    endcase
    ir_d = pc_reset ? {INSTR_W{1'b0}} : ir_d;
  end

  // fetch state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= {ADDR_W{1'b0}};
      stale_addr_q <= {ADDR_W{1'b0}};
      ir_q         <= {INSTR_W{1'b0}};
      pb_q         <= {INSTR_W{1'b0}};
      pb_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      stale_addr_q <= stale_addr_d;
      ir_q         <= ir_d;
      pb_q         <= pb_d;
      pb_valid_q   <= pb_valid_d;
    end
  end

  assign imem_req    = (state_q != ST_FULL);
  assign imem_addr   = (state_q == ST_DISCARD) ? stale_addr_q : pc_q;
  assign opcode_old  = instr_opcode(ir_q);
  assign operand     = instr_operand(ir_q);
  assign opcode_new  = pb_valid_q ? instr_opcode(pb_q) : OP_HLT;
  assign fetch_stall = ~pb_valid_q;

  rep_counter #(
    .REP_W(REP_W)
  ) u_rep_counter (
    .clk       (clk),
    .reset     (reset),
    .rep_reset (rep_reset),
    .rep_enable(rep_enable),
    .limit     (instr_count(ir_q)),
    .rep_stop  (rep_stop)
  );

`ifdef FETCH_PARITY_EN
  logic perr_q, perr_d;
  logic accept;

  assign accept = ((state_q == ST_FETCH) || (state_q == ST_WAIT)) && imem_ack && !redirect;

  // sticky parity error, cleared by pc_reset
  always_comb begin
    perr_d = perr_q;
    if (pc_reset) begin
      perr_d = 1'b0;
    end else if (accept && parity_fail(imem_rdata, imem_parity)) begin
      perr_d = 1'b1;
    end else begin
      perr_d = perr_q;
    end
  end

  // parity error register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`endif

endmodule
